// File: rtl/qenc_decoder.sv
`default_nettype none
// ============================================================================
// Module      : qenc_decoder
// Description : x4 quadrature-encoder receiver. Synchronizes and glitch-filters
//               A/B, tracks a signed position and flags illegal transitions.
// Revision    : 1.0 - initial release
// ============================================================================
module qenc_decoder #(
    parameter int FILT_LEN = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             inc,
    output logic             dec,
    output logic             dir,
    output logic             err,
    output logic             ready
);

    localparam logic [7:0]       c_filt_len = 8'(FILT_LEN);
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t     r_state;
    logic [1:0] r_init_cnt;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_prev;
    logic [1:0] w_filt;
    logic       w_load;
    logic       w_is_run;
    logic       w_cw;
    logic       w_ccw;
    logic       w_bad;

    // Bit 1 carries phase A, bit 0 carries phase B throughout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= {a, b};
            r_sync2 <= r_sync1;
        end
    end

    assign w_load   = (r_state == ST_INIT) && (r_init_cnt == 2'd2);
    assign w_is_run = (r_state == ST_RUN);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filt
            logic       r_lvl;
            logic [7:0] r_run;
            logic [7:0] w_run_nxt;

            assign w_run_nxt = r_run + 8'd1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lvl <= 1'b0;
                    r_run <= 8'd0;
                end else if (w_load) begin
                    r_lvl <= r_sync2[gi];
                    r_run <= 8'd0;
                end else if (w_is_run) begin
                    if (r_sync2[gi] == r_lvl) begin
                        r_run <= 8'd0;
                    end else if (w_run_nxt == c_filt_len) begin
                        r_lvl <= r_sync2[gi];
                        r_run <= 8'd0;
                    end else begin
                        r_run <= w_run_nxt;
                    end
                end
            end

            assign w_filt[gi] = r_lvl;
        end
    endgenerate

    always_comb begin
        w_cw  = 1'b0;
        w_ccw = 1'b0;
        w_bad = 1'b0;
        case ({r_prev, w_filt})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_cw  = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_ccw = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_bad = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= 2'd0;
            r_prev     <= 2'b00;
            cnt        <= '0;
            inc        <= 1'b0;
            dec        <= 1'b0;
            dir        <= 1'b0;
            err        <= 1'b0;
            ready      <= 1'b0;
        end else begin
            inc <= 1'b0;
            dec <= 1'b0;
            err <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    // Pin levels seen at startup become the reference, never a step.
                    if (r_init_cnt == 2'd2) begin
                        r_prev  <= r_sync2;
                        r_state <= ST_RUN;
                        ready   <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + 2'd1;
                    end
                end
                ST_RUN: begin
                    r_prev <= w_filt;
                    inc    <= w_cw;
                    dec    <= w_ccw;
                    err    <= w_bad;
                    if (w_cw) begin
                        dir <= 1'b0;
                    end else if (w_ccw) begin
                        dir <= 1'b1;
                    end
                    if (clr) begin
                        cnt <= '0;
                    end else if (w_cw) begin
                        cnt <= cnt + c_one;
                    end else if (w_ccw) begin
                        cnt <= cnt - c_one;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_qenc_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_qenc_decoder
// Description : Directed self-checking bench for qenc_decoder (16-bit and
//               4-bit counter instances share the same pins).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qenc_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a   = 1'b0;
    logic        b   = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] cnt;
    logic        inc, dec, dir, err, ready;
    logic [3:0]  cnt4;
    logic        inc4, dec4, dir4, err4, ready4;

    int vectors     = 0;
    int miscompares = 0;

    int n_inc, n_dec, n_err, inc_at, dec_at, err_at, n_inc4, n_other4;

    logic [1:0] cw_seq  [4] = '{2'b10, 2'b11, 2'b01, 2'b00};
    logic [1:0] ccw_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};

    qenc_decoder #(.FILT_LEN(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
        .cnt(cnt), .inc(inc), .dec(dec), .dir(dir), .err(err), .ready(ready)
    );

    qenc_decoder #(.FILT_LEN(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .a(a), .b(b), .clr(clr),
        .cnt(cnt4), .inc(inc4), .dec(dec4), .dir(dir4), .err(err4), .ready(ready4)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Drive pins at a falling edge, then observe `cycles` rising edges.
    // k=1 is edge E0, so a pulse at E(FILT_LEN+2)=E6 is reported at k=7.
    // clr is high only for the rising edge numbered clr_k (0 = never).
    task automatic watch(input logic na, input logic nb, input int cycles, input int clr_k);
        n_inc = 0; n_dec = 0; n_err = 0; n_inc4 = 0; n_other4 = 0;
        inc_at = 0; dec_at = 0; err_at = 0;
        @(negedge clk);
        a = na;
        b = nb;
        for (int k = 1; k <= cycles; k++) begin
            if (k > 1) @(negedge clk);
            clr = (k == clr_k);
            @(posedge clk);
            #1;
            if (inc) begin n_inc++; if (inc_at == 0) inc_at = k; end
            if (dec) begin n_dec++; if (dec_at == 0) dec_at = k; end
            if (err) begin n_err++; if (err_at == 0) err_at = k; end
            if (inc4) n_inc4++;
            if (dec4 || err4) n_other4++;
        end
        clr = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        a   = 1'b0;
        b   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++; if ({cnt, inc, dec, dir, err, ready} !== 21'd0) begin
            miscompares++; $display("FAIL reset_outputs: got %0h expected 0", {cnt, inc, dec, dir, err, ready});
        end
        vectors++; if ({cnt4, ready4} !== 5'd0) begin
            miscompares++; $display("FAIL reset_outputs4: got %0h expected 0", {cnt4, ready4});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            vectors++; if (ready !== (k == 3)) begin
                miscompares++; $display("FAIL reset_ready_edge%0d: got %b expected %b", k, ready, (k == 3));
            end
        end
        repeat (5) @(posedge clk);
        #1;
        vectors++; if ({cnt, err} !== 17'd0) begin
            miscompares++; $display("FAIL reset_settle: got %0h expected 0", {cnt, err});
        end
    endtask

    task automatic test_cw();
        for (int i = 0; i < 4; i++) begin
            watch(cw_seq[i][1], cw_seq[i][0], 20, 0);
            vectors++; if (n_inc !== 1 || n_dec !== 0 || n_err !== 0) begin
                miscompares++; $display("FAIL cw_pulses step%0d: got inc=%0d dec=%0d err=%0d expected 1/0/0", i, n_inc, n_dec, n_err);
            end
            vectors++; if (inc_at !== 7) begin
                miscompares++; $display("FAIL cw_latency step%0d: got edge %0d expected 7 (E6)", i, inc_at);
            end
        end
        vectors++; if (cnt !== 16'd4 || dir !== 1'b0) begin
            miscompares++; $display("FAIL cw_final: got cnt=%0h dir=%b expected 4/0", cnt, dir);
        end
    endtask

    task automatic test_ccw();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            watch(ccw_seq[i][1], ccw_seq[i][0], 20, 0);
            vectors++; if (n_dec !== 1 || n_inc !== 0 || n_err !== 0 || dec_at !== 7) begin
                miscompares++; $display("FAIL ccw_pulses step%0d: got dec=%0d@%0d inc=%0d err=%0d expected 1@7/0/0", i, n_dec, dec_at, n_inc, n_err);
            end
        end
        vectors++; if (cnt !== 16'hFFFC || dir !== 1'b1) begin
            miscompares++; $display("FAIL ccw_final: got cnt=%0h dir=%b expected fffc/1", cnt, dir);
        end
    endtask

    task automatic test_bounce();
        int glitch_pulses;
        glitch_pulses = 0;
        do_reset();
        for (int g = 0; g < 30; g++) begin
            @(negedge clk);
            a = 1'b1;
            repeat (3) begin @(posedge clk); #1; glitch_pulses += int'(inc | dec | err); end
            @(negedge clk);
            a = 1'b0;
            repeat (2) begin @(posedge clk); #1; glitch_pulses += int'(inc | dec | err); end
        end
        vectors++; if (glitch_pulses !== 0 || cnt !== 16'd0) begin
            miscompares++; $display("FAIL bounce_glitches: got pulses=%0d cnt=%0h expected 0/0", glitch_pulses, cnt);
        end
        watch(1'b1, 1'b0, 20, 0);
        vectors++; if (n_inc !== 1 || inc_at !== 7 || cnt !== 16'd1) begin
            miscompares++; $display("FAIL bounce_stable: got inc=%0d@%0d cnt=%0h expected 1@7 cnt=1", n_inc, inc_at, cnt);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        watch(1'b1, 1'b1, 20, 0);
        vectors++; if (n_err !== 1 || err_at !== 7 || n_inc !== 0 || n_dec !== 0 || cnt !== 16'd0) begin
            miscompares++; $display("FAIL illegal_err: got err=%0d@%0d inc=%0d dec=%0d cnt=%0h expected 1@7/0/0/0", n_err, err_at, n_inc, n_dec, cnt);
        end
        watch(1'b0, 1'b1, 20, 0);
        vectors++; if (n_inc !== 1 || n_err !== 0 || cnt !== 16'd1) begin
            miscompares++; $display("FAIL illegal_recover: got inc=%0d err=%0d cnt=%0h expected 1/0/1", n_inc, n_err, cnt);
        end
    endtask

    task automatic test_wrap_clr();
        int total_inc4;
        int total_other4;
        total_inc4   = 0;
        total_other4 = 0;
        do_reset();
        for (int i = 0; i < 15; i++) begin
            watch(cw_seq[i % 4][1], cw_seq[i % 4][0], 8, 0);
            total_inc4   += n_inc4;
            total_other4 += n_other4;
        end
        vectors++; if (cnt4 !== 4'd15 || cnt !== 16'd15 || total_inc4 !== 15 || total_other4 !== 0) begin
            miscompares++; $display("FAIL wrap_preload: got cnt4=%0h cnt=%0h inc4=%0d other4=%0d expected f/f/15/0", cnt4, cnt, total_inc4, total_other4);
        end
        watch(cw_seq[3][1], cw_seq[3][0], 8, 0);
        vectors++; if (cnt4 !== 4'd0 || n_inc4 !== 1 || cnt !== 16'd16) begin
            miscompares++; $display("FAIL wrap_overflow: got cnt4=%0h inc4=%0d cnt=%0h expected 0/1/10", cnt4, n_inc4, cnt);
        end
        watch(cw_seq[0][1], cw_seq[0][0], 10, 7);
        vectors++; if (n_inc !== 1 || inc_at !== 7 || n_inc4 !== 1) begin
            miscompares++; $display("FAIL clr_inc_pulse: got inc=%0d@%0d inc4=%0d expected 1@7/1", n_inc, inc_at, n_inc4);
        end
        vectors++; if (cnt !== 16'd0 || cnt4 !== 4'd0 || dir4 !== 1'b0) begin
            miscompares++; $display("FAIL clr_cnt: got cnt=%0h cnt4=%0h dir4=%b expected 0/0/0", cnt, cnt4, dir4);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        int ready_at;
        pulses   = 0;
        ready_at = 0;
        watch(1'b0, 1'b0, 10, 0);
        watch(1'b0, 1'b1, 10, 0);
        watch(1'b1, 1'b1, 10, 0);
        vectors++; if (cnt !== 16'hFFFD || dir !== 1'b1) begin
            miscompares++; $display("FAIL midrst_pre: got cnt=%0h dir=%b expected fffd/1", cnt, dir);
        end
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        vectors++; if ({cnt, inc, dec, dir, err, ready} !== 21'd0) begin
            miscompares++; $display("FAIL midrst_async: got %0h expected 0", {cnt, inc, dec, dir, err, ready});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            pulses += int'(inc | dec | err);
            if (ready && ready_at == 0) ready_at = k;
        end
        vectors++; if (ready_at !== 3 || pulses !== 0 || cnt !== 16'd0) begin
            miscompares++; $display("FAIL midrst_release: got ready_at=%0d pulses=%0d cnt=%0h expected 3/0/0", ready_at, pulses, cnt);
        end
        watch(1'b0, 1'b1, 20, 0);
        vectors++; if (n_inc !== 1 || n_err !== 0 || cnt !== 16'd1 || dir !== 1'b0) begin
            miscompares++; $display("FAIL midrst_resume: got inc=%0d err=%0d cnt=%0h dir=%b expected 1/0/1/0", n_inc, n_err, cnt, dir);
        end
    endtask

    initial begin
        test_reset();
        test_cw();
        test_ccw();
        test_bounce();
        test_illegal();
        test_wrap_clr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
